// File: rtl/config_loader_if.sv
// ---------------------------------------------------------------------------
// config_loader_if
//   Bitstream word stream into the configuration loader.
//
//   Handshake: the source drives word_data/word_valid; the loader drives
//   word_ready. A word moves on a rising clock edge where word_valid and
//   word_ready are both high. Once word_valid is raised the source holds
//   word_data stable until that transfer. word_ready may depend on nothing
//   the source does in the same cycle.
//
//   Signals:
//     word_data   bitstream word, bit 0 shifted into the chain first
//     word_valid  word_data holds a word
//     word_ready  loader takes the word this cycle
//
//   Modports:
//     master  bitstream source (host interface or boot ROM reader)
//     slave   config_loader
// ---------------------------------------------------------------------------
interface config_loader_if #(
    parameter int WORD_WIDTH = 8
);
    logic [WORD_WIDTH-1:0] word_data;
    logic                  word_valid;
    logic                  word_ready;

    modport master (
        output word_data,
        output word_valid,
        input  word_ready
    );

    modport slave (
        input  word_data,
        input  word_valid,
        output word_ready
    );
endinterface

// File: rtl/config_loader.sv
// ---------------------------------------------------------------------------
// config_loader
//   Loads a configuration bitstream into the serial config chain of a row or
//   column of logic tiles. The chain is cleared, loaded LSB first from the
//   word stream, then recirculated once while its ones are counted. A match
//   with the ones counted during loading releases the fabric enable.
//
//   Ports:
//     clock            block and config-chain clock
//     nreset           asynchronous active-low reset
//     start            one-cycle pulse, begins a load from IDLE/DONE/ERROR
//     word_if          bitstream word stream (slave side)
//     config_data_out  serial bit to the chain head
//     config_enable    chain shift enable
//     config_nreset    chain reset, active low
//     config_return    chain tail output
//     fabric_enable    tile enable, high only in DONE
//     busy             high in CLEAR, LOAD, VERIFY
//     done             high in DONE
//     error            high in ERROR
//     debug_state      current FSM state encoding
// ---------------------------------------------------------------------------
module config_loader #(
    parameter int TILE_CONFIG_BITS = 29,
    parameter int TILE_COUNT       = 4,
    parameter int WORD_WIDTH       = 8,
    parameter int CLEAR_CYCLES     = 4
) (
    input  logic                   clock,
    input  logic                   nreset,
    input  logic                   start,
    config_loader_if.slave         word_if,
    output logic                   config_data_out,
    output logic                   config_enable,
    output logic                   config_nreset,
    input  logic                   config_return,
    output logic                   fabric_enable,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [2:0]             debug_state
);

    localparam int CHAIN_BITS = TILE_CONFIG_BITS * TILE_COUNT;
    localparam int CW         = $clog2(CHAIN_BITS + 1);
    localparam int SW         = $clog2(WORD_WIDTH + 1);
    localparam int KW         = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;

    localparam logic [CW-1:0] CHAIN_C    = CW'(CHAIN_BITS);
    localparam logic [CW-1:0] VER_LAST   = CW'(CHAIN_BITS - 1);
    localparam logic [CW-1:0] WORD_CW    = CW'(WORD_WIDTH);
    localparam logic [SW-1:0] WORD_SW    = SW'(WORD_WIDTH);
    localparam logic [KW-1:0] CLEAR_LAST = KW'(CLEAR_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_LOAD   = 3'd2,
        ST_VERIFY = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERROR  = 3'd5
    } state_t;

    state_t state, state_n;

    logic [WORD_WIDTH-1:0] sh_buf, sh_buf_n;
    logic [SW-1:0]         sh_cnt, sh_cnt_n;      // bits left in sh_buf
    logic [CW-1:0]         bits_loaded, bits_loaded_n;
    logic [CW-1:0]         ones_expected, ones_expected_n;
    logic [CW-1:0]         ones_seen, ones_seen_n;
    logic [CW-1:0]         ver_cnt, ver_cnt_n;
    logic [KW-1:0]         clr_cnt, clr_cnt_n;

    logic                  data_q, data_n;
    logic                  enable_n;
    logic                  recirc_q;
    logic                  word_ready_q, ready_n;

    logic                  accept;
    logic                  shift_bit;
    logic [CW-1:0]         remaining;
    logic [SW-1:0]         take;

    assign word_if.word_ready = word_ready_q;
    assign debug_state        = state;

    // During VERIFY the tail is fed straight back to the head. A flop in this
    // path would make the ring CHAIN_BITS+1 long and leave the contents
    // rotated after CHAIN_BITS shifts, so only the select is registered.
    assign config_data_out = recirc_q ? config_return : data_q;

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n         = state;
        sh_buf_n        = sh_buf;
        sh_cnt_n        = sh_cnt;
        bits_loaded_n   = bits_loaded;
        ones_expected_n = ones_expected;
        ones_seen_n     = ones_seen;
        ver_cnt_n       = ver_cnt;
        clr_cnt_n       = clr_cnt;
        data_n          = 1'b0;
        enable_n        = 1'b0;

        accept    = word_if.word_valid & word_ready_q;
        // Bits the chain still needs beyond those already driven or buffered;
        // the final word is cut down to this.
        remaining = CHAIN_C - bits_loaded - CW'(sh_cnt);
        take      = (remaining >= WORD_CW) ? WORD_SW : SW'(remaining);
        // An empty buffer forwards bit 0 of the arriving word directly, so
        // the first word costs no extra cycle.
        shift_bit = (sh_cnt == '0) ? word_if.word_data[0] : sh_buf[0];

        case (state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_n   = ST_CLEAR;
                    clr_cnt_n = '0;
                end
            end

            ST_CLEAR: begin
                sh_buf_n        = '0;
                sh_cnt_n        = '0;
                bits_loaded_n   = '0;
                ones_expected_n = '0;
                ones_seen_n     = '0;
                ver_cnt_n       = '0;
                if (clr_cnt == CLEAR_LAST) begin
                    state_n = ST_LOAD;
                end else begin
                    clr_cnt_n = clr_cnt + KW'(1);
                end
            end

            ST_LOAD: begin
                if (bits_loaded == CHAIN_C) begin
                    // Last bit entered the chain on this edge; recirculation
                    // starts with the next one.
                    state_n   = ST_VERIFY;
                    enable_n  = 1'b1;
                    ver_cnt_n = '0;
                end else begin
                    if (accept || (sh_cnt != '0)) begin
                        data_n          = shift_bit;
                        enable_n        = 1'b1;
                        bits_loaded_n   = bits_loaded + CW'(1);
                        ones_expected_n = ones_expected + CW'(shift_bit);
                    end
                    if (accept) begin
                        if (sh_cnt == '0) begin
                            sh_buf_n = word_if.word_data >> 1;
                            sh_cnt_n = take - SW'(1);
                        end else begin
                            sh_buf_n = word_if.word_data;
                            sh_cnt_n = take;
                        end
                    end else if (sh_cnt != '0) begin
                        sh_buf_n = sh_buf >> 1;
                        sh_cnt_n = sh_cnt - SW'(1);
                    end
                end
            end

            ST_VERIFY: begin
                enable_n    = 1'b1;
                ones_seen_n = ones_seen + CW'(config_return);
                if (ver_cnt == VER_LAST) begin
                    enable_n = 1'b0;
                    state_n  = (ones_seen_n == ones_expected) ? ST_DONE : ST_ERROR;
                end else begin
                    ver_cnt_n = ver_cnt + CW'(1);
                end
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase

        // Ready whenever the buffer will be empty or down to its last bit,
        // as long as the chain still needs more than is already held.
        ready_n = (state_n == ST_LOAD) && (sh_cnt_n <= SW'(1)) &&
                  ((bits_loaded_n + CW'(sh_cnt_n)) < CHAIN_C);
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            sh_buf        <= '0;
            sh_cnt        <= '0;
            bits_loaded   <= '0;
            ones_expected <= '0;
            ones_seen     <= '0;
            ver_cnt       <= '0;
            clr_cnt       <= '0;
            data_q        <= 1'b0;
            recirc_q      <= 1'b0;
            word_ready_q  <= 1'b0;
            config_enable <= 1'b0;
            config_nreset <= 1'b0;
            fabric_enable <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
        end else begin
            sh_buf        <= sh_buf_n;
            sh_cnt        <= sh_cnt_n;
            bits_loaded   <= bits_loaded_n;
            ones_expected <= ones_expected_n;
            ones_seen     <= ones_seen_n;
            ver_cnt       <= ver_cnt_n;
            clr_cnt       <= clr_cnt_n;
            data_q        <= data_n;
            recirc_q      <= (state_n == ST_VERIFY);
            word_ready_q  <= ready_n;
            config_enable <= enable_n;
            config_nreset <= (state_n != ST_CLEAR);
            fabric_enable <= (state_n == ST_DONE);
            busy          <= (state_n == ST_CLEAR) || (state_n == ST_LOAD) ||
                             (state_n == ST_VERIFY);
            done          <= (state_n == ST_DONE);
            error         <= (state_n == ST_ERROR);
        end
    end

endmodule

// File: tb/tb_config_loader.sv
// ---------------------------------------------------------------------------
// tb_config_loader
//   Drives config_loader (2 tiles x 29 bits = 58-bit chain, 8-bit words)
//   against a 58-flop chain model. Bits handed over on the word stream are
//   queued and compared against config_data_out as the loader shifts them.
// ---------------------------------------------------------------------------
module tb_config_loader;

    localparam int CHAIN   = 58;
    localparam int MIN_CYC = 1 + 4 + CHAIN + CHAIN;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CLEAR = 3'd1;
    localparam logic [2:0] ST_LOAD  = 3'd2;

    localparam logic [CHAIN-1:0] STUCK_MASK = {1'b0, {(CHAIN-1){1'b1}}};

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic nreset;
    logic start;

    always #5 clock = ~clock;

    // ---------------- DUT ----------------
    config_loader_if #(.WORD_WIDTH(8)) word_if ();

    logic       config_data_out;
    logic       config_enable;
    logic       config_nreset;
    logic       config_return;
    logic       fabric_enable;
    logic       busy;
    logic       done;
    logic       error;
    logic [2:0] debug_state;

    config_loader #(
        .TILE_CONFIG_BITS (29),
        .TILE_COUNT       (2),
        .WORD_WIDTH       (8),
        .CLEAR_CYCLES     (4)
    ) dut (
        .clock           (clock),
        .nreset          (nreset),
        .start           (start),
        .word_if         (word_if),
        .config_data_out (config_data_out),
        .config_enable   (config_enable),
        .config_nreset   (config_nreset),
        .config_return   (config_return),
        .fabric_enable   (fabric_enable),
        .busy            (busy),
        .done            (done),
        .error           (error),
        .debug_state     (debug_state)
    );

    // ---------------- chain model ----------------
    // chain[0] is the head, chain[CHAIN-1] the tail. With stuck_en the tail
    // flop always holds 0.
    logic [CHAIN-1:0] chain    = '0;
    logic             stuck_en = 1'b0;

    always @(posedge clock) begin
        if (!config_nreset) begin
            chain <= '0;
        end else if (config_enable) begin
            chain <= stuck_en ? ({chain[CHAIN-2:0], config_data_out} & STUCK_MASK)
                              : {chain[CHAIN-2:0], config_data_out};
        end
    end

    assign config_return = chain[CHAIN-1];

    // ---------------- scoreboard state ----------------
    logic [0:0] exp_q[$];
    logic [7:0] words [0:8];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         bits_pushed;
    int         bits_popped;
    int         tx_count;
    int         late_ready;
    int         gap_cycles;
    int         nrst_low;
    int         clr_ready;
    int         cyc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Stream bit k (k-th bit shifted) ends at chain position CHAIN-1-k.
    function automatic logic [63:0] exp_chain();
        logic [63:0] r;
        r = '0;
        for (int k = 0; k < CHAIN; k++) begin
            r[CHAIN-1-k] = words[k / 8][k % 8];
        end
        return r;
    endfunction

    // ---------------- driver ----------------
    // Pulses start and feeds words until done/error, a timeout, or (when
    // abort_bits is non-zero) that many bits have been shifted.
    task automatic do_load(input bit gappy, input bit poke, input int abort_bits,
                           output int cycles);
        int       idx;
        bit       xfer;
        bit       ph;
        logic     exp_bit;
        int       limit;
        limit = 400;
        idx = 0;
        ph = 1'b0;
        cycles = 0;
        exp_q.delete();
        bits_pushed = 0;
        bits_popped = 0;
        tx_count = 0;
        late_ready = 0;
        gap_cycles = 0;
        nrst_low = 0;
        clr_ready = 0;
        word_if.word_data  = words[0];
        word_if.word_valid = gappy ? ph : 1'b1;

        @(posedge clock); #1;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        check("start_to_clear", 64'(debug_state), 64'(ST_CLEAR));
        check("fabric_drops", 64'(fabric_enable), 64'd0);
        check("busy_on_start", 64'(busy), 64'd1);
        if (!config_nreset) begin
            nrst_low++;
            if (word_if.word_ready) clr_ready++;
        end

        while (!(done || error) && cycles < limit &&
               !(abort_bits != 0 && bits_popped >= abort_bits)) begin
            @(negedge clock);
            if (debug_state == ST_LOAD) begin
                if (config_enable) begin
                    exp_bit = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
                    check("sb_bit", 64'(config_data_out), 64'(exp_bit));
                    bits_popped++;
                end else begin
                    gap_cycles++;
                end
            end
            if (word_if.word_ready && tx_count >= 8) late_ready++;
            xfer = word_if.word_valid && word_if.word_ready;
            if (xfer) begin
                tx_count++;
                for (int b = 0; b < 8; b++) begin
                    if (bits_pushed < CHAIN) begin
                        exp_q.push_back(word_if.word_data[b]);
                        bits_pushed++;
                    end
                end
            end

            @(posedge clock); #1;
            cycles++;
            if (xfer && idx < 8) idx++;
            ph = ~ph;
            word_if.word_data  = words[idx];
            word_if.word_valid = gappy ? ph : 1'b1;
            start = poke && (cycles == 2 || cycles == 30 || cycles == 100);
            if (!config_nreset) begin
                nrst_low++;
                if (word_if.word_ready) clr_ready++;
            end
        end
        start = 1'b0;
        word_if.word_valid = 1'b0;
        if (abort_bits == 0) check("load_timeout", 64'(cycles < limit), 64'd1);
    endtask

    task automatic check_good_load(input string tag);
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_fabric"}, 64'(fabric_enable), 64'd1);
        check({tag, "_error"}, 64'(error), 64'd0);
        check({tag, "_tx"}, 64'(tx_count), 64'd8);
        check({tag, "_late_ready"}, 64'(late_ready), 64'd0);
        check({tag, "_bits"}, 64'(bits_popped), 64'(CHAIN));
        check({tag, "_q_empty"}, 64'(exp_q.size()), 64'd0);
        check({tag, "_chain"}, 64'(chain), exp_chain());
        check({tag, "_clear_len"}, 64'(nrst_low), 64'd4);
        check({tag, "_clear_ready"}, 64'(clr_ready), 64'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        nreset = 1'b1;
        start = 1'b0;
        word_if.word_data = '0;
        word_if.word_valid = 1'b0;
        #2 nreset = 1'b0;
        #1;
        check("rst_cfg_nreset", 64'(config_nreset), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_enable", 64'(config_enable), 64'd0);
        check("rst_fabric", 64'(fabric_enable), 64'd0);
        check("rst_done_err", 64'({done, error}), 64'd0);
        check("rst_ready", 64'(word_if.word_ready), 64'd0);
        check("rst_state", 64'(debug_state), 64'(ST_IDLE));
        repeat (2) @(posedge clock);
        @(negedge clock) nreset = 1'b1;
        @(posedge clock); #1;
        check("idle_cfg_nreset", 64'(config_nreset), 64'd1);
        check("idle_busy", 64'(busy), 64'd0);

        // Words 0x01..0x08 plus an extra word that must never be taken.
        for (int i = 0; i < 8; i++) words[i] = 8'(i + 1);
        words[8] = 8'hA5;
        do_load(1'b0, 1'b0, 0, cyc);
        check("t1_cycles", 64'(cyc), 64'(MIN_CYC));
        check("t1_no_bubble", 64'(gap_cycles), 64'd1);
        check_good_load("t1");

        // Valid toggling: each idle LOAD cycle delays completion by one.
        do_load(1'b1, 1'b0, 0, cyc);
        check("t2_gaps_seen", 64'(gap_cycles > 1), 64'd1);
        check("t2_cycles", 64'(cyc), 64'(MIN_CYC + gap_cycles - 1));
        check_good_load("t2");

        // Start pulses in CLEAR, LOAD and VERIFY; run starts from DONE.
        do_load(1'b0, 1'b1, 0, cyc);
        check("t3_ignored_starts", 64'(cyc), 64'(MIN_CYC));
        check_good_load("t3");

        // Stuck tail flop with an all-ones bitstream.
        for (int i = 0; i < 9; i++) words[i] = 8'hFF;
        stuck_en = 1'b1;
        do_load(1'b0, 1'b0, 0, cyc);
        check("t4_error", 64'(error), 64'd1);
        check("t4_fabric", 64'(fabric_enable), 64'd0);
        check("t4_done", 64'(done), 64'd0);
        check("t4_cycles", 64'(cyc), 64'(MIN_CYC));
        stuck_en = 1'b0;

        // Reset in the middle of LOAD, then a clean reload of random words.
        for (int i = 0; i < 9; i++) words[i] = 8'($urandom_range(0, 255));
        do_load(1'b0, 1'b0, 20, cyc);
        check("t5_in_load", 64'(debug_state), 64'(ST_LOAD));
        nreset = 1'b0;
        #1;
        check("t5_cfg_nreset", 64'(config_nreset), 64'd0);
        check("t5_busy", 64'(busy), 64'd0);
        check("t5_enable", 64'(config_enable), 64'd0);
        check("t5_ready", 64'(word_if.word_ready), 64'd0);
        repeat (2) @(posedge clock);
        @(negedge clock) nreset = 1'b1;
        @(posedge clock); #1;
        check("t5_idle", 64'(debug_state), 64'(ST_IDLE));
        check("t5_idle_cfg_nreset", 64'(config_nreset), 64'd1);
        do_load(1'b0, 1'b0, 0, cyc);
        check("t5_cycles", 64'(cyc), 64'(MIN_CYC));
        check_good_load("t5");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
